pulse_emitter: RTL

PULSE_EMITTER -- requirements
Module: pulse_emitter

---
 rtl/pulse_emitter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pulse_emitter.sv
// pulse_emitter: fixed-length active-low pulse followed by a holdoff window.
// Define PULSE_EMITTER_PENDING_EN to queue one request that arrives while busy.
module pulse_emitter #(
  parameter logic [15:0] PULSE_LEN   = 16'h00ff,
  parameter logic [15:0] HOLDOFF_LEN = 16'hf00f
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iTRIG,
  output logic oPULSE_n,
  output logic oBUSY,
  output logic oDONE,
  output logic oDROP
);

  // A zero pulse length still produces a one-cycle pulse.
  localparam logic [15:0] PULSE_LAST   = (PULSE_LEN == 16'd0) ? 16'd0 : PULSE_LEN - 16'd1;
  localparam logic [15:0] HOLDOFF_LAST = (HOLDOFF_LEN == 16'd0) ? 16'd0 : HOLDOFF_LEN - 16'd1;
  localparam logic        NO_HOLDOFF   = (HOLDOFF_LEN == 16'd0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t      stateReg, stateNext;
  logic [15:0] cntReg, cntNext, cntInc;
  logic        dropStageReg, dropStageNext;
  logic        doneNext;
  logic        busyReq;
  logic        lastCycle;
`ifdef PULSE_EMITTER_PENDING_EN
  logic        pendReg, pendNext;
`endif

  always_comb begin
    cntInc        = (cntReg == 16'hffff) ? cntReg : cntReg + 16'd1;
    busyReq       = iTRIG && (stateReg != IDLE);
    stateNext     = stateReg;
    cntNext       = cntInc;
    doneNext      = 1'b0;
    lastCycle     = 1'b0;
    dropStageNext = 1'b0;
`ifdef PULSE_EMITTER_PENDING_EN
    pendNext      = pendReg;
`endif

    case (stateReg)
      IDLE: begin
        cntNext = 16'd0;
        if (iTRIG) stateNext = ASSERT;
      end
      ASSERT: begin
        if (cntReg == PULSE_LAST) begin
          cntNext = 16'd0;
          if (NO_HOLDOFF) lastCycle = 1'b1;
          else            stateNext = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cntReg == HOLDOFF_LAST) lastCycle = 1'b1;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 16'd0;
      end
    endcase

`ifdef PULSE_EMITTER_PENDING_EN
    // A request seen on the exit edge itself still counts as pending.
    pendNext      = pendReg | busyReq;
    dropStageNext = busyReq && pendReg;
    if (lastCycle) begin
      doneNext = 1'b1;
      cntNext  = 16'd0;
      if (pendNext) begin
        stateNext = ASSERT;
        pendNext  = 1'b0;
      end else begin
        stateNext = IDLE;
      end
    end
`else
    dropStageNext = busyReq;
    if (lastCycle) begin
      doneNext  = 1'b1;
      cntNext   = 16'd0;
      stateNext = IDLE;
    end
`endif
  end

  // Outputs are registered from the next state so they change on the same edge.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stateReg     <= IDLE;
      cntReg       <= 16'd0;
      dropStageReg <= 1'b0;
      oPULSE_n     <= 1'b1;
      oBUSY        <= 1'b0;
      oDONE        <= 1'b0;
      oDROP        <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      dropStageReg <= dropStageNext;
      oPULSE_n     <= (stateNext != ASSERT);
      oBUSY        <= (stateNext != IDLE);
      oDONE        <= doneNext;
      oDROP        <= dropStageReg;
    end
  end

`ifdef PULSE_EMITTER_PENDING_EN
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) pendReg <= 1'b0;
    else         pendReg <= pendNext;
  end
`endif

endmodule
